// File: rtl/sched_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot/index grant and a valid/ready handshake.
// Optional grant locking is enabled by defining RR_ARB_LOCK_EN.
module sched_rr_arbiter #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             lock_i,
  input  logic             gnt_ready_i,
  output logic             gnt_valid_o,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic [IDX_W-1:0] ptr_o
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  localparam logic [IDX_W:0]   NReqW   = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0]   oh_q, oh_d;
  logic [IDX_W-1:0]   next_ptr, base, win_idx;
  logic [N_REQ-1:0]   rot, win_oh;
  logic [2*N_REQ-1:0] dbl;
  logic [IDX_W:0]     off, sum;
  logic               hs, keep;

  assign hs       = (state_q == StPresent) && gnt_ready_i;
  assign next_ptr = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
  // On a handshake the search already uses the advanced pointer (1 grant/cycle).
  assign base     = hs ? next_ptr : ptr_q;

`ifdef RR_ARB_LOCK_EN
  assign keep = lock_i & req_i[idx_q];
`else
  logic unused_lock;
  assign unused_lock = lock_i;
  assign keep        = 1'b0;
`endif

  // Rotate requests so that bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    dbl = {req_i, req_i} >> base;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W+1)'(i);
    end
    sum = {1'b0, base} + off;
    if (sum >= NReqW) sum = sum - NReqW;
    win_idx = sum[IDX_W-1:0];
    win_oh  = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StPresent;
          idx_d   = win_idx;
          oh_d    = win_oh;
        end
      end
      StPresent: begin
        if (hs) begin
          if (keep) begin
            ptr_d = ptr_q;
          end else if (|req_i) begin
            ptr_d = next_ptr;
            idx_d = win_idx;
            oh_d  = win_oh;
          end else begin
            ptr_d   = next_ptr;
            state_d = StIdle;
            idx_d   = '0;
            oh_d    = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
    end
  end

  assign gnt_valid_o = (state_q == StPresent);
  assign gnt_oh_o    = oh_q;
  assign gnt_idx_o   = idx_q;
  assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_sched_rr_arbiter.sv
// Bench for sched_rr_arbiter: directed scenarios plus a randomized run against a
// behavioural round-robin model.
module tb_sched_rr_arbiter;

  localparam int N = 8;
`ifdef RR_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = '0;
  logic       lock = 1'b0;
  logic       ready = 1'b0;
  logic       gnt_valid;
  logic [7:0] gnt_oh;
  logic [2:0] gnt_idx;
  logic [2:0] ptr;

  int total = 0;
  int bad = 0;

  // Model state
  bit m_valid = 1'b0;
  int m_idx = 0;
  int m_ptr = 0;

  sched_rr_arbiter #(.N_REQ(8), .IDX_W(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .lock_i      (lock),
    .gnt_ready_i (ready),
    .gnt_valid_o (gnt_valid),
    .gnt_oh_o    (gnt_oh),
    .gnt_idx_o   (gnt_idx),
    .ptr_o       (ptr)
  );

  always #5 clk = ~clk;

  function automatic int search(input logic [7:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j[2:0]]) return j;
    end
    return 0;
  endfunction

  function automatic logic [7:0] exp_oh();
    logic [7:0] v;
    v = '0;
    if (m_valid) v[m_idx[2:0]] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle outputs.
  task automatic tick(input logic [7:0] r, input logic rd, input logic lk, input logic rs);
    @(negedge clk);
    req = r; ready = rd; lock = lk; rst = rs;
    @(posedge clk);
    if (rs) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (!m_valid) begin
      if (r != 0) begin
        m_valid = 1; m_idx = search(r, m_ptr);
      end
    end else if (rd) begin
      if (!(LockEn && lk && r[m_idx[2:0]])) begin
        m_ptr = (m_idx + 1) % N;
        if (r != 0) m_idx = search(r, m_ptr);
        else begin
          m_valid = 0; m_idx = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid); end
    total++; if (gnt_oh !== 8'h00) begin bad++; $display("FAIL reset_oh got=%h want=00", gnt_oh); end
    total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
    total++; if (ptr !== 3'd0) begin bad++; $display("FAIL reset_ptr got=%0d want=0", ptr); end
  endtask

  task automatic test_round_robin();
    int exp_seq[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick(8'hFF, 1'b1, 1'b0, 1'b0);
      total++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'(exp_seq[c])) begin
        bad++; $display("FAIL rr_seq[%0d] got v=%b idx=%0d want v=1 idx=%0d", c, gnt_valid, gnt_idx, exp_seq[c]);
      end
    end
    tick(8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (gnt_valid !== 1'b0 || ptr !== 3'd2) begin
      bad++; $display("FAIL rr_drain got v=%b ptr=%0d want v=0 ptr=2", gnt_valid, ptr);
    end
  endtask

  task automatic test_stall();
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    tick(8'h24, 1'b0, 1'b0, 1'b0);
    total++; if (gnt_idx !== 3'd2 || gnt_oh !== 8'h04) begin
      bad++; $display("FAIL stall_load got idx=%0d oh=%h want idx=2 oh=04", gnt_idx, gnt_oh);
    end
    for (int c = 0; c < 3; c++) begin
      tick(8'h01, 1'b0, 1'b0, 1'b0);
      total++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || gnt_oh !== 8'h04 || ptr !== 3'd0) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%b idx=%0d oh=%h ptr=%0d want v=1 idx=2 oh=04 ptr=0",
                        c, gnt_valid, gnt_idx, gnt_oh, ptr);
      end
    end
    tick(8'h01, 1'b1, 1'b0, 1'b0);
    total++; if (gnt_idx !== 3'd0 || gnt_oh !== 8'h01 || ptr !== 3'd3 || gnt_valid !== 1'b1) begin
      bad++; $display("FAIL stall_release got idx=%0d oh=%h ptr=%0d want idx=0 oh=01 ptr=3", gnt_idx, gnt_oh, ptr);
    end
  endtask

  task automatic test_wrap();
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    tick(8'h80, 1'b1, 1'b0, 1'b0);
    total++; if (gnt_idx !== 3'd7 || gnt_oh !== 8'h80) begin
      bad++; $display("FAIL wrap_grant got idx=%0d oh=%h want idx=7 oh=80", gnt_idx, gnt_oh);
    end
    tick(8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (ptr !== 3'd0 || gnt_valid !== 1'b0 || gnt_oh !== 8'h00 || gnt_idx !== 3'd0) begin
      bad++; $display("FAIL wrap_idle got ptr=%0d v=%b oh=%h idx=%0d want ptr=0 v=0 oh=00 idx=0",
                      ptr, gnt_valid, gnt_oh, gnt_idx);
    end
  endtask

  task automatic test_reset_mid();
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) tick(8'hFF, 1'b1, 1'b0, 1'b0);
    tick(8'hFF, 1'b1, 1'b0, 1'b1);
    total++; if (gnt_valid !== 1'b0 || ptr !== 3'd0 || gnt_oh !== 8'h00) begin
      bad++; $display("FAIL rst_mid got v=%b ptr=%0d oh=%h want v=0 ptr=0 oh=00", gnt_valid, ptr, gnt_oh);
    end
    tick(8'hFF, 1'b1, 1'b0, 1'b0);
    total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
      bad++; $display("FAIL rst_first got v=%b idx=%0d want v=1 idx=0", gnt_valid, gnt_idx);
    end
  endtask

  task automatic test_lock();
    int exp_seq[5];
    logic lk_seq[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if (LockEn) exp_seq = '{1, 1, 1, 1, 2};
    else        exp_seq = '{1, 2, 1, 2, 1};
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick(8'h06, c != 0, lk_seq[c], 1'b0);
      total++;
      if (gnt_idx !== 3'(exp_seq[c])) begin
        bad++; $display("FAIL lock_seq[%0d] got idx=%0d want idx=%0d", c, gnt_idx, exp_seq[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] p_oh, r;
    logic [2:0] p_idx;
    logic       p_valid, p_ready, rd, lk, rs;
    tick(8'h00, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      p_valid = gnt_valid; p_oh = gnt_oh; p_idx = gnt_idx;
      r  = 8'($urandom) & 8'($urandom);
      rd = ($urandom_range(0, 2) != 0);
      lk = $urandom_range(0, 1) == 1;
      rs = ($urandom_range(0, 99) == 0);
      p_ready = rd;
      tick(r, rd, lk, rs);
      total++;
      if (gnt_valid !== m_valid || gnt_oh !== exp_oh() || gnt_idx !== 3'(m_idx) || ptr !== 3'(m_ptr)) begin
        bad++; $display("FAIL rand_model[%0d] got v=%b oh=%h idx=%0d ptr=%0d want v=%b oh=%h idx=%0d ptr=%0d",
                        c, gnt_valid, gnt_oh, gnt_idx, ptr, m_valid, exp_oh(), m_idx, m_ptr);
      end
      total++;
      if (!$onehot0(gnt_oh) || (gnt_valid && gnt_oh[gnt_idx] !== 1'b1) || (!gnt_valid && gnt_oh !== 8'h00)) begin
        bad++; $display("FAIL rand_onehot[%0d] got oh=%h idx=%0d v=%b want consistent", c, gnt_oh, gnt_idx, gnt_valid);
      end
      if (p_valid && !p_ready && !rs) begin
        total++;
        if (gnt_valid !== 1'b1 || gnt_oh !== p_oh || gnt_idx !== p_idx) begin
          bad++; $display("FAIL rand_stall[%0d] got v=%b oh=%h idx=%0d want v=1 oh=%h idx=%0d",
                          c, gnt_valid, gnt_oh, gnt_idx, p_oh, p_idx);
        end
      end
      if (gnt_valid && !rs && (!p_valid || p_ready)) begin
        total++;
        if (r[gnt_idx] !== 1'b1) begin
          bad++; $display("FAIL rand_nonreq[%0d] got idx=%0d req=%h want requesting index", c, gnt_idx, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
